// File: rtl/tft_pattern_gen.sv
// rtl/tft_pattern_gen.sv - RGB565 test-pattern source for the 480x272 TFT path
// Optional 1-pixel white border overlay: define TFT_PAT_BORDER_EN.
module tft_pattern_gen #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int BAR_STEP = 4,
  parameter int BAR_W    = 32,
  parameter int CHK_LOG2 = 4
) (
  input  logic        Clk9M,
  input  logic        Rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        TFT_VS,
  input  logic [2:0]  mode_sel,
  output logic [15:0] data_out,
  output logic [2:0]  mode_cur,
  output logic [15:0] frame_cnt,
  output logic        frame_tick
);

  localparam logic [10:0] H_A   = 11'(H_ACTIVE);
  localparam logic [10:0] V_A   = 11'(V_ACTIVE);
  localparam logic [10:0] STEP  = 11'(BAR_STEP);
  localparam logic [10:0] BW    = 11'(BAR_W);
  localparam int          VB_W  = H_ACTIVE / 8;
  localparam int          HB_H  = V_ACTIVE / 8;

  logic        vs_d_q, vs_d_d;
  logic        frame_tick_q, frame_tick_d;
  logic [2:0]  mode_cur_q, mode_cur_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [10:0] bar_pos_q, bar_pos_d;
  logic        started_q, started_d;
  logic [15:0] data_out_q, data_out_d;

  logic [10:0] h11, v11, bar_sum, bar_end;
  logic [2:0]  vbar_idx, hbar_idx;
  logic        in_range, bar_lit;
  logic [15:0] pat;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  // Frame-start bookkeeping; updates land at the end of the tick cycle.
  always_comb begin
    vs_d_d       = TFT_VS;
    frame_tick_d = TFT_VS & ~vs_d_q;
    mode_cur_d   = mode_cur_q;
    frame_cnt_d  = frame_cnt_q;
    bar_pos_d    = bar_pos_q;
    started_d    = started_q;
    bar_sum      = bar_pos_q + STEP;
    if (frame_tick_q) begin
      mode_cur_d  = mode_sel;
      frame_cnt_d = frame_cnt_q + 16'd1;
      bar_pos_d   = (bar_sum >= H_A) ? bar_sum - H_A : bar_sum;
      started_d   = 1'b1;
    end
  end

  // Bar indices come from comparator chains against multiples of the bar size.
  always_comb begin
    h11      = {1'b0, hcount};
    v11      = {1'b0, vcount};
    vbar_idx = 3'd0;
    hbar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h11 >= 11'(k * VB_W)) vbar_idx = vbar_idx + 3'd1;
      if (v11 >= 11'(k * HB_H)) hbar_idx = hbar_idx + 3'd1;
    end
    bar_end  = bar_pos_q + BW;
    bar_lit  = ((h11 >= bar_pos_q) && (h11 < bar_end)) ||
               ((bar_end > H_A) && (h11 < bar_end - H_A));
    in_range = (h11 < H_A) && (v11 < V_A);
  end

  always_comb begin
    pat = 16'h0000;
    case (mode_cur_q)
      3'd0:    pat = 16'hFFFF;
      3'd1:    pat = bar_colour(vbar_idx);
      3'd2:    pat = bar_colour(hbar_idx);
      3'd3:    pat = (hcount[CHK_LOG2] ^ vcount[CHK_LOG2]) ? 16'hFFFF : 16'h0000;
      3'd4:    pat = bar_lit ? 16'hFFFF : 16'h0000;
      3'd5:    pat = {hcount[8:4], 11'd0};
      default: pat = 16'h0000;
    endcase
`ifdef TFT_PAT_BORDER_EN
    if ((h11 == 11'd0) || (h11 == H_A - 11'd1) || (v11 == 11'd0) || (v11 == V_A - 11'd1))
      pat = 16'hFFFF;
`endif
    // Black until the first frame tick after reset has latched a mode.
    data_out_d = (in_range && started_q) ? pat : 16'h0000;
  end

  always_ff @(posedge Clk9M or posedge Rst) begin
    if (Rst) begin
      vs_d_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      mode_cur_q   <= 3'd0;
      frame_cnt_q  <= 16'd0;
      bar_pos_q    <= 11'd0;
      started_q    <= 1'b0;
      data_out_q   <= 16'h0000;
    end else begin
      vs_d_q       <= vs_d_d;
      frame_tick_q <= frame_tick_d;
      mode_cur_q   <= mode_cur_d;
      frame_cnt_q  <= frame_cnt_d;
      bar_pos_q    <= bar_pos_d;
      started_q    <= started_d;
      data_out_q   <= data_out_d;
    end
  end

  assign data_out   = data_out_q;
  assign mode_cur   = mode_cur_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_tft_pattern_gen.sv
// tb/tb_tft_pattern_gen.sv - directed self-checking bench for tft_pattern_gen
module tb_tft_pattern_gen;

  logic        clk9m = 1'b0;
  logic        rst;
  logic [9:0]  hcount, vcount;
  logic        tft_vs;
  logic [2:0]  mode_sel;
  logic [15:0] data_out;
  logic [2:0]  mode_cur;
  logic [15:0] frame_cnt;
  logic        frame_tick;

  int n_checks = 0;
  int n_pass   = 0;
  int bm;

  tft_pattern_gen dut (
    .Clk9M(clk9m), .Rst(rst), .hcount(hcount), .vcount(vcount), .TFT_VS(tft_vs),
    .mode_sel(mode_sel), .data_out(data_out), .mode_cur(mode_cur),
    .frame_cnt(frame_cnt), .frame_tick(frame_tick)
  );

  always #5 clk9m = ~clk9m;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk9m);
    #1;
  endtask

  task automatic pix(input string tag, input int hh, input int vv, input logic [15:0] exp);
    hcount = 10'(hh);
    vcount = 10'(vv);
    step();
    check(tag, data_out, exp);
  endtask

  task automatic vs_frame();
    tft_vs = 1'b1;
    step();
    step();
    tft_vs = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0; tft_vs = 1'b0; hcount = '0; vcount = '0; mode_sel = 3'd0;
    #2 rst = 1'b1;
    #1;
    check("rst_async_data", data_out, 16'h0000);
    check("rst_async_cnt", frame_cnt, 16'd0);
    check("rst_async_mode", {13'd0, mode_cur}, 16'd0);
    check("rst_async_tick", {15'd0, frame_tick}, 16'd0);
    repeat (20) step();
    check("rst_hold_data", data_out, 16'h0000);
    rst = 1'b0;
    pix("pre_tick_black", 10, 10, 16'h0000);

    // Mode 1 vertical bars
    mode_sel = 3'd1;
    tft_vs = 1'b1;
    step();
    check("tick_high", {15'd0, frame_tick}, 16'd1);
    check("mode_not_yet", {13'd0, mode_cur}, 16'd0);
    step();
    check("tick_low", {15'd0, frame_tick}, 16'd0);
    check("mode1_latched", {13'd0, mode_cur}, 16'd1);
    check("cnt1", frame_cnt, 16'd1);
    tft_vs = 1'b0;
    step();
    pix("vbar_h59", 59, 10, 16'hFFFF);
    pix("vbar_h60", 60, 10, 16'hFFE0);
    pix("vbar_h300", 300, 10, 16'hF800);
    pix("vbar_h479", 479, 10, 16'h0000);
    pix("vbar_v272", 100, 272, 16'h0000);

    // Mode 4 moving bar over 120 frames
    bm = 4;
    mode_sel = 3'd4;
    for (int f = 0; f < 120; f++) begin
      vs_frame();
      bm = (bm + 4) % 480;
      pix("bar_head", bm, 50, 16'hFFFF);
      pix("bar_before", (bm + 479) % 480, 50, 16'h0000);
      if (bm == 464) begin
        pix("bar464_h470", 470, 50, 16'hFFFF);
        pix("bar464_h15", 15, 50, 16'hFFFF);
        pix("bar464_h16", 16, 50, 16'h0000);
      end
    end
    check("cnt121", frame_cnt, 16'd121);

    // Mode 5 red ramp
    mode_sel = 3'd5;
    vs_frame();
    pix("ramp_h479", 479, 5, 16'hE800);
    pix("ramp_h16", 16, 5, 16'h0800);

    // Mode 3 checker, mid-frame request ignored
    mode_sel = 3'd3;
    vs_frame();
    mode_sel = 3'd2;
    step();
    check("mode_holds3", {13'd0, mode_cur}, 16'd3);
    pix("chk_h16v0", 16, 0, 16'hFFFF);
    pix("chk_h20v20", 20, 20, 16'h0000);
    pix("chk_h5v20", 5, 20, 16'hFFFF);
    vs_frame();
    check("mode2_latched", {13'd0, mode_cur}, 16'd2);
    pix("hbar_v33", 100, 33, 16'hFFFF);
    pix("hbar_v34", 100, 34, 16'hFFE0);
    pix("hbar_v250", 100, 250, 16'h0000);
    pix("hbar_h480", 480, 100, 16'h0000);

    // Blanking and solid / black modes
    mode_sel = 3'd0;
    vs_frame();
    pix("white_h480", 480, 5, 16'h0000);
    pix("white_v272", 5, 272, 16'h0000);
    pix("white_mid", 200, 100, 16'hFFFF);
    mode_sel = 3'd6;
    vs_frame();
    pix("black6_mid", 200, 100, 16'h0000);
`ifdef TFT_PAT_BORDER_EN
    pix("border_h0", 0, 100, 16'hFFFF);
`else
    pix("noborder_h0", 0, 100, 16'h0000);
`endif
    mode_sel = 3'd7;
    vs_frame();
    pix("black7_mid", 200, 100, 16'h0000);

    // Reset mid-line in mode 1
    mode_sel = 3'd1;
    vs_frame();
    pix("pre_rst_px", 10, 3, 16'hFFFF);
    #2 rst = 1'b1;
    #1;
    check("midrst_data", data_out, 16'h0000);
    check("midrst_mode", {13'd0, mode_cur}, 16'd0);
    check("midrst_cnt", frame_cnt, 16'd0);
    step();
    rst = 1'b0;
    step();
    check("postrst_mode", {13'd0, mode_cur}, 16'd0);
    pix("postrst_black", 10, 3, 16'h0000);
    vs_frame();
    check("postrst_cnt1", frame_cnt, 16'd1);
    check("postrst_mode1", {13'd0, mode_cur}, 16'd1);
    pix("postrst_px", 10, 3, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
